// File: rtl/matrix_pkg.sv
// Shared state encodings, stream-mode constants and width helper for the
// matrix buffer and the multiplier datapath that consumes it.
package matrix_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CLEAR  = 2'd1,
    ST_STREAM = 2'd2
  } state_t;

  localparam logic STR_ROW = 1'b0;
  localparam logic STR_COL = 1'b1;

  // Index width that never collapses to zero bits for single-entry dimensions.
  function automatic int clog2_min1(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/matrix_stream_ctrl.sv
// Sequencer for the matrix buffer: IDLE/CLEAR/STREAM FSM, element counter,
// registered stream output with valid/ready handshake.
module matrix_stream_ctrl
  import matrix_pkg::*;
#(
  parameter int ROWS  = 2,
  parameter int COLS  = 2,
  parameter int WIDTH = 8,
  parameter int SW    = 1,
  parameter int AW    = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_start,
  input  logic             str_start,
  input  logic             str_mode,
  input  logic [SW-1:0]    str_index,
  input  logic             str_ready,
  input  logic [WIDTH-1:0] elem_data,
  output logic [AW-1:0]    elem_addr,
  output logic             clr_we,
  output logic [AW-1:0]    clr_addr,
  output logic             clearing,
  output logic             busy,
  output logic [WIDTH-1:0] str_data,
  output logic             str_valid,
  output logic             str_last
);

  localparam int N     = ROWS * COLS;
  localparam int CNT_W = clog2_min1(N + 1);

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt;
  logic             mode_q;
  logic [SW-1:0]    index_q;
  logic             accept, advance, finish, idx_ok;
  logic             ld_mode, ld_last;
  logic [SW-1:0]    ld_idx;
  int               ld_pos, ld_len, ld_lin;

  always_comb begin
    idx_ok     = (str_mode == STR_ROW) ? (int'(str_index) < ROWS) : (int'(str_index) < COLS);
    state_next = state;
    accept     = 1'b0;
    advance    = 1'b0;
    finish     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (clr_start) begin
          state_next = ST_CLEAR;
        end else if (str_start && idx_ok) begin
          state_next = ST_STREAM;
          accept     = 1'b1;
        end
      end
      ST_CLEAR: begin
        if (int'(cnt) == N - 1) state_next = ST_IDLE;
      end
      ST_STREAM: begin
        // One drain cycle with str_valid low follows the final handshake.
        if (!str_valid) begin
          state_next = ST_IDLE;
        end else if (str_ready) begin
          if (str_last) finish = 1'b1;
          else          advance = 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase

    ld_mode   = accept ? str_mode  : mode_q;
    ld_idx    = accept ? str_index : index_q;
    ld_pos    = accept ? 0 : int'(cnt) + 1;
    ld_len    = (ld_mode == STR_ROW) ? COLS : ROWS;
    ld_lin    = (ld_mode == STR_ROW) ? int'(ld_idx) * COLS + ld_pos
                                     : ld_pos * COLS + int'(ld_idx);
    ld_last   = (ld_pos == ld_len - 1);
    elem_addr = AW'(ld_lin);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      mode_q    <= STR_ROW;
      index_q   <= '0;
      str_data  <= '0;
      str_valid <= 1'b0;
      str_last  <= 1'b0;
    end else begin
      state <= state_next;
      if (state == ST_CLEAR || advance) cnt <= cnt + CNT_W'(1);
      else if (state == ST_IDLE)        cnt <= '0;
      if (accept) begin
        mode_q  <= str_mode;
        index_q <= str_index;
      end
      if (accept || advance) begin
        str_data  <= elem_data;
        str_valid <= 1'b1;
        str_last  <= ld_last;
      end else if (finish) begin
        str_valid <= 1'b0;
        str_last  <= 1'b0;
      end
    end
  end

  assign busy     = (state != ST_IDLE);
  assign clearing = (state == ST_CLEAR);
  assign clr_we   = clearing;
  assign clr_addr = AW'(cnt);

endmodule

// File: rtl/matrix_buffer.sv
// ROWSxCOLS element store with (row,col) write, registered random read,
// sequenced clear and a row/column streaming port for the MAC stage.
module matrix_buffer
  import matrix_pkg::*;
#(
  parameter  int ROWS  = 2,
  parameter  int COLS  = 2,
  parameter  int WIDTH = 8,
  localparam int RW    = clog2_min1(ROWS),
  localparam int CW    = clog2_min1(COLS),
  localparam int SW    = (RW > CW) ? RW : CW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [RW-1:0]    wr_row,
  input  logic [CW-1:0]    wr_col,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [RW-1:0]    rd_row,
  input  logic [CW-1:0]    rd_col,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  input  logic             clr_start,
  input  logic             str_start,
  input  logic             str_mode,
  input  logic [SW-1:0]    str_index,
  output logic [WIDTH-1:0] str_data,
  output logic             str_valid,
  input  logic             str_ready,
  output logic             str_last,
  output logic             busy
);

  localparam int N  = ROWS * COLS;
  localparam int AW = clog2_min1(N);

  logic [WIDTH-1:0] mem [N];
  logic [AW-1:0]    wr_addr, rd_addr, elem_addr, clr_addr;
  logic             wr_ok, rd_ok, wr_hit, clr_we, clearing;
  logic [WIDTH-1:0] elem_data;

  assign wr_ok   = (int'(wr_row) < ROWS) && (int'(wr_col) < COLS);
  assign rd_ok   = (int'(rd_row) < ROWS) && (int'(rd_col) < COLS);
  assign wr_addr = AW'(int'(wr_row) * COLS + int'(wr_col));
  assign rd_addr = AW'(int'(rd_row) * COLS + int'(rd_col));
  assign wr_hit  = wr_en && wr_ok && !clearing;

  assign elem_data = (int'(elem_addr) < N) ? mem[elem_addr] : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N; i++) mem[i] <= '0;
    end else if (clr_we) begin
      mem[clr_addr] <= '0;
    end else if (wr_hit) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Read samples the array before this edge's write lands, so a same-cycle
  // read of the written element returns the old value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) rd_data <= rd_ok ? mem[rd_addr] : '0;
    end
  end

  matrix_stream_ctrl #(
    .ROWS (ROWS),
    .COLS (COLS),
    .WIDTH(WIDTH),
    .SW   (SW),
    .AW   (AW)
  ) u_ctrl (
    .clk      (clk),
    .rst      (rst),
    .clr_start(clr_start),
    .str_start(str_start),
    .str_mode (str_mode),
    .str_index(str_index),
    .str_ready(str_ready),
    .elem_data(elem_data),
    .elem_addr(elem_addr),
    .clr_we   (clr_we),
    .clr_addr (clr_addr),
    .clearing (clearing),
    .busy     (busy),
    .str_data (str_data),
    .str_valid(str_valid),
    .str_last (str_last)
  );

endmodule
